// File: rtl/main_mem_ctrl.sv
// Main-memory model behind a cache: one 128-bit line per request, moved as four
// 32-bit beats after a programmable access latency, with a one-cycle ready response.

package cache_def;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

endpackage

module main_mem_ctrl
    import cache_def::*;
#(
    parameter int LINES   = 1024,
    parameter int LATENCY = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  mem_req_type  mem_req_i,
    output mem_data_type mem_data_o,
    output logic         busy_o,
    output logic [31:0]  no_rd_o,
    output logic [31:0]  no_wr_o,
    output logic         drop_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, BEAT, RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         wait_q;
    logic [1:0]         beat_q;
    logic [IDX_W-1:0]   line_q;
    logic [127:0]       wdata_q;
    logic               rw_q;
    logic [95:0]        lbuf_q;
    logic [127:0]       rdata_q;
    logic               accept;
    logic               busy;
    logic [31:0]        rd_word;
    logic [IDX_W+1:0]   word_idx;

    // Backing store is zero at time 0 and intentionally survives reset.
    logic [31:0] store [LINES*4] = '{default: '0};

    // Address bits outside the line index are don't-care.
    logic unused_addr;
    assign unused_addr = ^{mem_req_i.addr[31:IDX_W+4], mem_req_i.addr[3:0]};

    assign busy     = (state_q == WAIT) || (state_q == BEAT);
    assign accept   = mem_req_i.valid && ((state_q == IDLE) || (state_q == RESP));
    assign word_idx = {line_q, beat_q};
    assign rd_word  = store[word_idx];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (LATENCY == 0) ? BEAT : WAIT;
            WAIT: if (wait_q == 4'd0) state_d = BEAT;
            BEAT: if (beat_q == 2'd3) state_d = RESP;
            RESP: begin
                if (accept) state_d = (LATENCY == 0) ? BEAT : WAIT;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            lbuf_q  <= '0;
            rdata_q <= '0;
            no_rd_o <= '0;
            no_wr_o <= '0;
            drop_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                line_q  <= mem_req_i.addr[IDX_W+3:4];
                wdata_q <= mem_req_i.data;
                rw_q    <= mem_req_i.rw;
                wait_q  <= WAIT_INIT;
                beat_q  <= 2'd0;
                if (mem_req_i.rw) no_wr_o <= no_wr_o + 32'd1;
                else              no_rd_o <= no_rd_o + 32'd1;
            end
            if (mem_req_i.valid && busy) drop_o <= 1'b1;
            if (state_q == WAIT && wait_q != 4'd0) wait_q <= wait_q - 4'd1;
            if (state_q == BEAT) begin
                beat_q <= beat_q + 2'd1;
                // Output only changes once the whole line has been gathered.
                if (!rw_q) begin
                    if (beat_q == 2'd3) rdata_q <= {rd_word, lbuf_q};
                    else                lbuf_q[{beat_q, 5'b0} +: 32] <= rd_word;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == BEAT && rw_q)
            store[word_idx] <= wdata_q[{beat_q, 5'b0} +: 32];
    end

    assign busy_o           = busy;
    assign mem_data_o.ready = (state_q == RESP);
    assign mem_data_o.data  = rdata_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: a LATENCY=4/LINES=1024 instance and a
// LATENCY=0/LINES=16 instance, each with its own line model and response queue.

module tb_main_mem_ctrl;
    import cache_def::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_req_type  req4, req0;
    mem_data_type rsp4, rsp0;
    logic         busy4, busy0, drop4, drop0;
    logic [31:0]  nrd4, nwr4, nrd0, nwr0;

    main_mem_ctrl #(.LINES(1024), .LATENCY(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req4), .mem_data_o(rsp4),
        .busy_o(busy4), .no_rd_o(nrd4), .no_wr_o(nwr4), .drop_o(drop4));

    main_mem_ctrl #(.LINES(16), .LATENCY(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req0), .mem_data_o(rsp0),
        .busy_o(busy0), .no_rd_o(nrd0), .no_wr_o(nwr0), .drop_o(drop0));

    typedef struct {
        int           cyc;
        logic [127:0] data;
    } exp_t;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    exp_t q4[$], q0[$];
    logic [127:0] m4[int], m0[int];
    logic [127:0] buf4 = '0, buf0 = '0;
    int rd4 = 0, wr4 = 0, rd0 = 0, wr0 = 0;
    int pulses4 = 0, pulses0 = 0;

    localparam logic [127:0] D1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
    localparam logic [127:0] D3 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    localparam logic [127:0] D4 = 128'h1357_9BDF_2468_ACE0_FFFF_0000_1234_8765;
    localparam logic [127:0] OLD = 128'hBBBB_BBBB_AAAA_AAAA_9999_9999_8888_8888;
    localparam logic [127:0] NEW = 128'h7777_7777_6666_6666_5555_5555_4444_4444;

    always @(negedge clk) begin
        if (rsp4.ready) begin
            exp_t e;
            pulses4++;
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL ready4_unexpected cyc=%0d data=%h", cyc, rsp4.data);
            end else begin
                e = q4.pop_front();
                if (rsp4.data !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL resp4 got cyc=%0d data=%h want cyc=%0d data=%h",
                             cyc, rsp4.data, e.cyc, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rsp0.ready) begin
            exp_t e;
            pulses0++;
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL ready0_unexpected cyc=%0d data=%h", cyc, rsp0.data);
            end else begin
                e = q0.pop_front();
                if (rsp0.data !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL resp0 got cyc=%0d data=%h want cyc=%0d data=%h",
                             cyc, rsp0.data, e.cyc, e.data);
                end
            end
        end
    end

    // Called in the low clock phase; the request is accepted on the next rising edge.
    task automatic issue(input bit z, input bit rw, input logic [31:0] a, input logic [127:0] d);
        int ln;
        exp_t e;
        if (z) begin
            ln = int'((a >> 4) % 16);
            e.cyc = cyc + 5;
            if (rw) begin e.data = buf0; m0[ln] = d; wr0++; end
            else begin e.data = m0.exists(ln) ? m0[ln] : '0; buf0 = e.data; rd0++; end
            q0.push_back(e);
            req0 = '{addr: a, data: d, rw: rw, valid: 1'b1};
        end else begin
            ln = int'((a >> 4) % 1024);
            e.cyc = cyc + 9;
            if (rw) begin e.data = buf4; m4[ln] = d; wr4++; end
            else begin e.data = m4.exists(ln) ? m4[ln] : '0; buf4 = e.data; rd4++; end
            q4.push_back(e);
            req4 = '{addr: a, data: d, rw: rw, valid: 1'b1};
        end
        @(posedge clk);
        #1;
        req0.valid = 1'b0;
        req4.valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q4.size() != 0 || q0.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (q4.size() != 0 || q0.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending4=%0d pending0=%0d want 0", q4.size(), q0.size());
            q4.delete();
            q0.delete();
        end
    endtask

    task automatic goto_cyc(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (rsp4.ready !== 1'b0) begin failures++; $display("FAIL rst_ready got %b want 0", rsp4.ready); end
        if (busy4 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy got %b/%b want 0", busy4, busy0); end
        if (drop4 !== 1'b0) begin failures++; $display("FAIL rst_drop got %b want 0", drop4); end
        if (rsp4.data !== '0 || rsp0.data !== '0) begin failures++; $display("FAIL rst_data got %h want 0", rsp4.data); end
        if (nrd4 !== 0 || nrd0 !== 0) begin failures++; $display("FAIL rst_no_rd got %0d want 0", nrd4); end
        if (nwr4 !== 0 || nwr0 !== 0) begin failures++; $display("FAIL rst_no_wr got %0d want 0", nwr4); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        issue(0, 1, 32'h0000_0040, D1);
        drain();
        issue(0, 0, 32'h0000_0040, '0);
        drain();
        checks += 2;
        if (nwr4 !== 32'(wr4)) begin failures++; $display("FAIL wr_count got %0d want %0d", nwr4, wr4); end
        if (nrd4 !== 32'(rd4)) begin failures++; $display("FAIL rd_count got %0d want %0d", nrd4, rd4); end
    endtask

    task automatic test_back_to_back();
        int t, p;
        p = pulses4;
        t = cyc;
        issue(0, 1, 32'h0000_0080, D2);
        goto_cyc(t + 9);
        issue(0, 0, 32'h0000_0040, '0);
        drain();
        checks++;
        if (pulses4 - p != 2) begin failures++; $display("FAIL b2b_pulses got %0d want 2", pulses4 - p); end
    endtask

    task automatic test_wrap();
        issue(0, 1, 32'h0001_0000, D3);
        drain();
        issue(0, 0, 32'h0000_0000, '0);
        drain();
    endtask

    task automatic test_drop();
        int t;
        checks++;
        if (drop4 !== 1'b0) begin failures++; $display("FAIL drop_pre got %b want 0", drop4); end
        t = cyc;
        issue(0, 0, 32'h0000_0080, '0);
        goto_cyc(t + 2);
        req4 = '{addr: 32'h0000_0200, data: '1, rw: 1'b1, valid: 1'b1};
        @(posedge clk);
        #1 req4.valid = 1'b0;
        checks++;
        if (drop4 !== 1'b1) begin failures++; $display("FAIL drop_set got %b want 1", drop4); end
        drain();
        checks += 3;
        if (drop4 !== 1'b1) begin failures++; $display("FAIL drop_sticky got %b want 1", drop4); end
        if (nwr4 !== 32'(wr4)) begin failures++; $display("FAIL drop_wr_count got %0d want %0d", nwr4, wr4); end
        if (nrd4 !== 32'(rd4)) begin failures++; $display("FAIL drop_rd_count got %0d want %0d", nrd4, rd4); end
        issue(0, 0, 32'h0000_0200, '0);
        drain();
    endtask

    task automatic test_reset_mid_write();
        int t;
        issue(0, 1, 32'h0000_0100, OLD);
        drain();
        t = cyc;
        issue(0, 1, 32'h0000_0100, NEW);
        goto_cyc(t + 7);
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (rsp4.ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got %b want 0", rsp4.ready); end
        if (busy4 !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got %b want 0", busy4); end
        if (rsp4.data !== '0) begin failures++; $display("FAIL mid_rst_data got %h want 0", rsp4.data); end
        if (nrd4 !== 0 || nwr4 !== 0) begin failures++; $display("FAIL mid_rst_counts got %0d/%0d want 0/0", nrd4, nwr4); end
        if (drop4 !== 1'b0) begin failures++; $display("FAIL mid_rst_drop got %b want 0", drop4); end
        q4.delete();
        m4[16] = {OLD[127:64], NEW[63:0]};
        buf4 = '0; buf0 = '0;
        rd4 = 0; wr4 = 0; rd0 = 0; wr0 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 0, 32'h0000_0100, '0);
        drain();
        checks++;
        if (nrd4 !== 32'd1 || nwr4 !== 32'd0) begin failures++; $display("FAIL post_rst_counts got %0d/%0d want 1/0", nrd4, nwr4); end
    endtask

    task automatic test_lat0();
        issue(1, 1, 32'h0000_0030, D4);
        drain();
        issue(1, 0, 32'h0000_0030, '0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (busy0 !== (c <= 4)) begin failures++; $display("FAIL lat0_busy cyc+%0d got %b want %b", c, busy0, (c <= 4)); end
        end
        drain();
        issue(1, 0, 32'h0000_0130, '0);
        drain();
        checks++;
        if (nrd0 !== 32'(rd0) || nwr0 !== 32'(wr0)) begin failures++; $display("FAIL lat0_counts got %0d/%0d want %0d/%0d", nrd0, nwr0, rd0, wr0); end
    endtask

    initial begin
        req4 = '0;
        req0 = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wrap();
        test_drop();
        test_reset_mid_write();
        test_lat0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 1024: number of 128-bit lines in the backing store; power of 2; IDX_W = log2(LINES).
REQ-002 SHALL have parameter LATENCY, default 4: access wait cycles before the first beat; range 0..15.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mem_req_i, input, mem_req_type (cache_def): addr[31:0], data[127:0], rw (1 = write), valid.
REQ-006 SHALL have port mem_data_o, output, mem_data_type (cache_def): data[127:0], ready.
REQ-007 SHALL have port busy_o, output, 1 bit: high while in WAIT or BEAT.
REQ-008 SHALL have port no_rd_o, output, 32 bits: count of accepted reads.
REQ-009 SHALL have port no_wr_o, output, 32 bits: count of accepted writes.
REQ-010 SHALL have port drop_o, output, 1 bit: sticky flag, set when valid is seen while busy.

Function
REQ-011 SHALL implement the state machine IDLE, WAIT, BEAT, RESP.
REQ-012 SHALL accept a request when mem_req_i.valid=1 in IDLE or RESP, latching addr, data and rw on that edge. valid is a single-cycle pulse, so the request is latched, not held.
REQ-013 On acceptance with LATENCY>0, SHALL go to WAIT and load the wait counter with LATENCY-1; on acceptance with LATENCY=0, SHALL go directly to BEAT.
REQ-014 In WAIT, SHALL decrement the counter each cycle and go to BEAT in the cycle after it reads 0 (exactly LATENCY WAIT cycles).
REQ-015 In BEAT, SHALL run 4 cycles with beat counter k = 0..3, then go to RESP.
REQ-016 On beat k of a write, SHALL write word data[32k+31:32k] to store[{line,k}].
REQ-017 On beat k of a read, SHALL load store[{line,k}] into line-buffer bits [32k+31:32k].
REQ-018 SHALL compute line = addr[IDX_W+3:4]; upper address bits SHALL be ignored, so addresses wrap modulo LINES. addr[3:0] SHALL be ignored.
REQ-019 SHALL hold RESP for exactly 1 cycle with mem_data_o.ready=1. For a read, mem_data_o.data SHALL equal the line read. For a write, data SHALL be the unchanged previous buffer value.
REQ-020 If valid=1 in RESP, SHALL accept the new request in that same cycle (back-to-back write-back then allocate) and SHALL NOT assert an extra ready for it. Otherwise SHALL go to IDLE.
REQ-021 mem_data_o.data SHALL be stable outside RESP and hold the last line buffer value.
REQ-022 ready SHALL be 0 in IDLE, WAIT and BEAT.
REQ-023 Response timing: for a request accepted in cycle t, ready SHALL be high in cycle t+LATENCY+5.
REQ-024 valid=1 in WAIT or BEAT SHALL be ignored (no latch, no count) and SHALL set drop_o.
REQ-025 no_rd_o / no_wr_o SHALL increment by 1 on each accepted read / write and SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 busy_o SHALL be combinational from the state register.
REQ-027 Backing store SHALL be initialised to all-zero at time 0 and SHALL NOT be cleared by reset.

Reset
REQ-028 While rst_ni=0, SHALL immediately force state to IDLE and set ready, busy_o, drop_o, mem_data_o.data, no_rd_o, no_wr_o, and the wait and beat counters to 0.
REQ-029 Reset mid-operation SHALL abort the transaction with no response. Words of an aborted write already written remain written; unwritten words are unchanged.
REQ-030 The first request SHALL be accepted no earlier than the first rising edge after rst_ni deasserts.

Verification
REQ-031 Write then read, LATENCY=4: write addr 0x0000_0040, data 0x4444_3333_2222_1111_..., then read the same addr -> each ready in cycle t+9; read data equals written line; no_wr_o=1, no_rd_o=1.
REQ-032 Back-to-back: write accepted, then valid read (different line) asserted in the write's RESP cycle -> read accepted in that same cycle; read ready 9 cycles later; exactly 2 ready pulses.
REQ-033 Wrap: LINES=1024, write to addr 0x0001_0000, read addr 0x0000_0000 -> read returns the written line.
REQ-034 Busy drop: valid pulse during WAIT -> ignored, drop_o=1 (sticky), counters unchanged, original response intact.
REQ-035 Reset mid-write at beat 2 -> outputs zero at once, no ready; subsequent read of that line returns words 0-1 new, words 2-3 old.
REQ-036 LATENCY=0: read accepted in cycle t -> ready in cycle t+5; busy_o high exactly in cycles t+1..t+4.
